// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: streams sequential fetches from a one-cycle-latency
// instruction memory into a small FIFO, with flush-and-refetch on redirect.
module instr_prefetch_queue #(
    parameter int unsigned        ADDR_W   = 64,
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [INSTR_W-1:0]        imem_rdata,
    output logic                      out_valid,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]         out_pc,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt_q;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0]  mem_pc    [DEPTH];

    logic               full_c;
    logic               credit_c;
    logic               pop_c;
    logic               push_c;
    logic [1:0]         unused_redirect_lsb;

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_redirect_lsb = redirect_pc[1:0];

    // Credit: never have more entries plus outstanding responses than slots.
    assign full_c   = (cnt_q == CNT_W'(DEPTH));
    assign credit_c = (SUM_W'(cnt_q) + SUM_W'(inflight)) < SUM_W'(DEPTH);
    assign imem_req = reset & ~redirect_valid & credit_c;
    assign imem_addr = fetch_pc;

    assign pop_c  = out_valid & out_ready & ~redirect_valid;
    assign push_c = inflight & ~redirect_valid & (~full_c | pop_c);

    // Fetch pointer, queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                req_pc   <= fetch_pc;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= req_pc;
        end
    end

    assign count     = cnt_q;
    assign out_valid = (cnt_q != '0);
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_prefetch_queue;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [63:0]        redirect_pc = 64'h0;
    logic               imem_req;
    logic [63:0]        imem_addr;
    logic [31:0]        imem_rdata = 32'h0;
    logic               out_valid;
    logic [31:0]        out_instr;
    logic [63:0]        out_pc;
    logic               out_ready = 1'b0;
    logic [2:0]         count;

    instr_prefetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: queued PCs, next fetch address, outstanding request.
    logic [63:0] m_q[$];
    logic [63:0] m_fetch;
    logic        m_infl;
    logic [63:0] m_infl_pc;
    logic [63:0] last_addr;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch   = RESET_PC;
        m_infl    = 1'b0;
        m_infl_pc = 64'h0;
        last_addr = 64'h0;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_req"},   64'(imem_req),  64'h0);
        check({pfx, "_valid"}, 64'(out_valid), 64'h0);
        check({pfx, "_instr"}, 64'(out_instr), 64'h0);
        check({pfx, "_pc"},    out_pc,         64'h0);
        check({pfx, "_count"}, 64'(count),     64'h0);
    endtask

    // Called at posedge+1; holds reset for one edge and releases it.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check_zero_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare against the model, advance both.
    task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
        logic        exp_req;
        logic [63:0] head;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        imem_rdata     = mem_fn(last_addr);
        #1;
        exp_req = ((m_q.size() + (m_infl ? 1 : 0)) < int'(DEPTH)) && !rv;
        check("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_fetch);
        check("count", 64'(count), 64'(m_q.size()));
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            head = m_q[0];
            check("out_pc", out_pc, head);
            check("out_instr", 64'(out_instr), 64'(mem_fn(head)));
        end
        last_addr = imem_addr;
        if (rv) begin
            m_q.delete();
            m_fetch = {rpc[63:2], 2'b00};
            m_infl  = 1'b0;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            if (exp_req) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 64'd4;
            end
            m_infl = exp_req;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fill with consumer stalled.
        repeat (8) step(1'b0, 64'h0, 1'b0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_head",  out_pc,     64'h0);
        check("fill_req",   64'(imem_req), 64'h0);

        // Streaming at one per cycle.
        do_reset();
        repeat (2) step(1'b0, 64'h0, 1'b1);
        check("stream_pc0", out_pc, 64'h0);
        step(1'b0, 64'h0, 1'b1);
        check("stream_pc1", out_pc, 64'h4);
        step(1'b0, 64'h0, 1'b1);
        check("stream_pc2", out_pc, 64'h8);

        // Redirect with three entries queued and one response in flight.
        do_reset();
        repeat (4) step(1'b0, 64'h0, 1'b0);
        check("pre_redir_count", 64'(count), 64'd3);
        step(1'b1, 64'h100, 1'b1);
        check("redir_count", 64'(count),     64'd0);
        check("redir_valid", 64'(out_valid), 64'd0);
        repeat (2) step(1'b0, 64'h0, 1'b1);
        check("redir_valid3", 64'(out_valid), 64'd1);
        check("redir_pc3",    out_pc,         64'h100);

        // Full queue, single pop.
        do_reset();
        repeat (8) step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        check("pop1_count", 64'(count), 64'd3);
        check("pop1_head",  out_pc,     64'h4);
        repeat (3) step(1'b0, 64'h0, 1'b0);
        check("refill_count", 64'(count), 64'd4);
        check("refill_head",  out_pc,     64'h4);

        // Address wrap, then asynchronous reset mid-stream.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        repeat (2) step(1'b0, 64'h0, 1'b1);
        check("wrap_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 64'h0, 1'b1);
        check("wrap_pc_zero", out_pc, 64'h0);
        step(1'b0, 64'h0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Back-to-back redirects: the later target wins.
        repeat (3) step(1'b0, 64'h0, 1'b1);
        step(1'b1, 64'h200, 1'b1);
        step(1'b1, 64'h300, 1'b1);
        repeat (2) step(1'b0, 64'h0, 1'b1);
        check("b2b_pc", out_pc, 64'h300);
        repeat (4) step(1'b0, 64'h0, 1'b1);

        // Random traffic with unaligned redirect targets.
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [63:0] rpc;
            logic        rdy;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = {32'($urandom), 32'($urandom)};
            rdy = ($urandom_range(0, 3) != 0);
            step(rv, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter ADDR_W, default 64, PC and address width in bits.
REQ-002 Parameter INSTR_W, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, 2 to 32.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-007 redirect_valid  input  1  branch or jump taken; flush the queue and refetch.
REQ-008 redirect_pc  input  ADDR_W  new fetch address; sampled when redirect_valid=1.
REQ-009 imem_req  output  1  instruction memory read request this cycle.
REQ-010 imem_addr  output  ADDR_W  read address; valid when imem_req=1.
REQ-011 imem_rdata  input  INSTR_W  read data; valid exactly 1 cycle after imem_req.
REQ-012 out_valid  output  1  head entry available.
REQ-013 out_instr  output  INSTR_W  head instruction.
REQ-014 out_pc  output  ADDR_W  PC of the head instruction.
REQ-015 out_ready  input  1  consumer accepts the head; pop when out_valid and out_ready are both 1.
REQ-016 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 fetch_pc register: imem_addr = fetch_pc; it advances by 4 modulo 2^ADDR_W on every cycle where imem_req=1 and redirect_valid=0.
REQ-018 imem_req = 1 iff count + inflight < DEPTH and redirect_valid = 0.
- inflight = 1 when a request was issued in the previous cycle and its response has not been squashed; otherwise 0.
REQ-019 Response capture: the cycle after an unsquashed request, {imem_rdata, request PC} is written at the write pointer on the rising edge.
REQ-020 Latency: a request in cycle N gives out_valid=1 in cycle N+2 when the queue was empty; there is no combinational bypass.
REQ-021 Output: out_instr and out_pc come from the read-pointer entry; out_valid = (count != 0).
- out_instr and out_pc are held stable while out_valid=1 and out_ready=0.
REQ-022 Pointers: read and write pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-023 Simultaneous push and pop: both take effect, count is unchanged, and order is preserved.
REQ-024 Full: the credit rule in REQ-018 guarantees a response never arrives while full. A write while full is a design error and shall not corrupt entries.
REQ-025 Redirect in cycle N: at the edge ending cycle N:
- count becomes 0 and both pointers reset to 0;
- fetch_pc becomes redirect_pc;
- any response for a request issued in cycle N-1 is squashed and discarded in cycle N;
- a pop in cycle N is ignored.
REQ-026 Redirect in cycle N: imem_req=0 in cycle N; fetching at redirect_pc starts in cycle N+1.
REQ-027 Back-to-back redirects: the last one wins; a redirect_pc not yet fetched is overwritten.
REQ-028 redirect_pc shall be 4-byte aligned; bits [1:0] are ignored and forced to 0.
REQ-029 With out_ready held at 1 and no redirects, throughput is one instruction per cycle.

Reset
REQ-030 While reset=0, asynchronously:
- fetch_pc = RESET_PC and count = 0;
- pointers = 0 and inflight = 0;
- out_valid = 0 and imem_req = 0;
- out_instr and out_pc = 0.
REQ-031 Entry storage shall not require reset.
REQ-032 Reset deassertion: imem_req=1 with imem_addr=RESET_PC on the first cycle after release.
REQ-033 Reset asserted mid-operation discards queue contents and any inflight response with no residual output.

Verification
REQ-034 Release reset, out_ready=0, DEPTH=4 -> requests at 0x0, 0x4, 0x8, 0xC; count reaches 4; imem_req=0 thereafter; out_pc=0x0.
REQ-035 Stream, out_ready=1 -> out_valid from cycle 2 after release; out_pc sequence 0x0, 0x4, 0x8 at one per cycle.
REQ-036 Redirect to 0x100 while count=3 with one request inflight:
- next cycle: count=0, out_valid=0, and the inflight data is never output;
- then out_pc=0x100 appears 3 cycles after the redirect.
REQ-037 Full queue with out_ready=1 for one cycle -> exactly one pop and one new request; count stays within 3 to 4; the order of out_pc is preserved.
REQ-038 fetch_pc at 2^ADDR_W-4 -> the next out_pc is 0 (wrap); then assert reset=0 mid-stream -> all outputs are 0 immediately.
REQ-039 Redirects in two consecutive cycles to 0x200 then 0x300 -> the first out_pc is 0x300; 0x200 is never fetched.
